// File: rtl/ct_spsram_512x22_ctrl.sv
// ct_spsram_512x22_ctrl
//   Controller for a single-port 512x22 SRAM macro. After reset, and on every
//   inv_start_i request, it sweeps the whole array and writes INIT_DATA to
//   each entry. Outside a sweep it accepts one read or write per cycle and
//   drives the SRAM pins combinationally in the accepting cycle. Read data
//   comes back one cycle later.
//
// Ports
//   forever_cpuclk_i  clock, rising edge
//   cpurst_b_i        synchronous active-low reset
//   req_vld_i/req_rdy_o          request handshake
//   req_wr_i                     1 = write, 0 = read
//   req_addr_i/req_wdata_i/req_wmask_i  entry index, write data, per-bit write enable
//   rsp_vld_o/rsp_rdata_o        read response (rdata holds the last response)
//   inv_start_i                  invalidate (re-initialise) the whole array
//   init_busy_o                  high while an init sweep is running
//   sram_a_o/sram_d_o/sram_cen_o/sram_gwen_o/sram_wen_o  SRAM controls (enables active-low)
//   sram_q_i                     SRAM read data, valid one cycle after a read
module ct_spsram_512x22_ctrl #(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 22,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA  = '0
) (
  input  logic                  forever_cpuclk_i,
  input  logic                  cpurst_b_i,
  input  logic                  req_vld_i,
  output logic                  req_rdy_o,
  input  logic                  req_wr_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [DATA_WIDTH-1:0] req_wmask_i,
  output logic                  rsp_vld_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  input  logic                  inv_start_i,
  output logic                  init_busy_o,
  output logic [ADDR_WIDTH-1:0] sram_a_o,
  output logic [DATA_WIDTH-1:0] sram_d_o,
  output logic                  sram_cen_o,
  output logic                  sram_gwen_o,
  output logic [DATA_WIDTH-1:0] sram_wen_o,
  input  logic [DATA_WIDTH-1:0] sram_q_i
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rdy;
  logic                    accept;

  // Acceptance is only possible in IDLE; an invalidate request in the same
  // cycle takes priority and blocks the request.
  assign rdy    = cpurst_b_i && (state_q == ST_IDLE) && !inv_start_i;
  assign accept = req_vld_i && rdy;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_pend_d = accept && !req_wr_i;
    // Capture the SRAM output while a response is on the bus so rdata holds
    // afterwards even though sram_q may change.
    rdata_d   = rd_pend_q ? sram_q_i : rdata_q;
    case (state_q)
      ST_INIT: begin
        // Counter wraps to zero on the last entry, ready for the next sweep.
        cnt_d = cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (inv_start_i) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge forever_cpuclk_i) begin
    if (!cpurst_b_i) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      rdata_q   <= rdata_d;
    end
  end

  // SRAM pins. Reset gates everything off so a reset landing mid-sweep does
  // not issue a stray write. Idle cycles pass the request fields through to
  // avoid extra muxing on the address/data paths.
  always_comb begin
    sram_cen_o  = 1'b1;
    sram_gwen_o = 1'b1;
    sram_wen_o  = {DATA_WIDTH{1'b1}};
    sram_a_o    = req_addr_i;
    sram_d_o    = req_wdata_i;
    if (cpurst_b_i) begin
      if (state_q == ST_INIT) begin
        sram_cen_o  = 1'b0;
        sram_gwen_o = 1'b0;
        sram_wen_o  = '0;
        sram_a_o    = cnt_q;
        sram_d_o    = INIT_DATA;
      end else if (accept) begin
        if (!req_wr_i) begin
          sram_cen_o = 1'b0;
        end else if (req_wmask_i != '0) begin
          sram_cen_o  = 1'b0;
          sram_gwen_o = 1'b0;
          sram_wen_o  = ~req_wmask_i;
        end
      end
    end
  end

  // Response outputs are forced off while reset is held so a read in flight
  // is dropped immediately rather than on the next edge.
  assign req_rdy_o   = rdy;
  assign init_busy_o = !cpurst_b_i || (state_q == ST_INIT);
  assign rsp_vld_o   = cpurst_b_i && rd_pend_q;
  assign rsp_rdata_o = !cpurst_b_i ? '0 : (rd_pend_q ? sram_q_i : rdata_q);

endmodule

// File: tb/tb_ct_spsram_512x22_ctrl.sv
// tb_ct_spsram_512x22_ctrl
//   Directed self-checking bench for ct_spsram_512x22_ctrl. A behavioural
//   512x22 single-port SRAM with per-bit write enable sits on the SRAM pins.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.
module tb_ct_spsram_512x22_ctrl;

  logic        clk = 1'b0;
  logic        rstB;
  logic        reqVld;
  logic        reqRdy;
  logic        reqWr;
  logic [8:0]  reqAddr;
  logic [21:0] reqWdata;
  logic [21:0] reqWmask;
  logic        rspVld;
  logic [21:0] rspRdata;
  logic        invStart;
  logic        initBusy;
  logic [8:0]  sramA;
  logic [21:0] sramD;
  logic        sramCen;
  logic        sramGwen;
  logic [21:0] sramWen;
  logic [21:0] sramQ = '0;

  logic [21:0] mem [512];

  int testCount = 0;
  int failCount = 0;
  int sweepLen;
  logic sawRsp;

  ct_spsram_512x22_ctrl dut (
    .forever_cpuclk_i (clk),
    .cpurst_b_i       (rstB),
    .req_vld_i        (reqVld),
    .req_rdy_o        (reqRdy),
    .req_wr_i         (reqWr),
    .req_addr_i       (reqAddr),
    .req_wdata_i      (reqWdata),
    .req_wmask_i      (reqWmask),
    .rsp_vld_o        (rspVld),
    .rsp_rdata_o      (rspRdata),
    .inv_start_i      (invStart),
    .init_busy_o      (initBusy),
    .sram_a_o         (sramA),
    .sram_d_o         (sramD),
    .sram_cen_o       (sramCen),
    .sram_gwen_o      (sramGwen),
    .sram_wen_o       (sramWen),
    .sram_q_i         (sramQ)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: one access per edge, read data appears after the edge.
  always @(posedge clk) begin
    if (!sramCen) begin
      if (sramGwen) begin
        sramQ <= mem[sramA];
      end else begin
        mem[sramA] <= (mem[sramA] & sramWen) | (sramD & ~sramWen);
      end
    end
  end

  // Bench-wide guard so a stuck design cannot hang the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic wr, input logic [8:0] addr,
                               input logic [21:0] wdata, input logic [21:0] wmask,
                               input logic inv);
    reqVld   = vld;
    reqWr    = wr;
    reqAddr  = addr;
    reqWdata = wdata;
    reqWmask = wmask;
    invStart = inv;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clk);
  endtask

  // Runs idle cycles until req_rdy rises (bounded); len counts the cycles
  // spent before the ready cycle, sawR flags any response seen meanwhile.
  task automatic waitSweepDone(output int len, output logic sawR);
    int k;
    k    = 0;
    sawR = 1'b0;
    applyStimulus(1'b0, 1'b0, 9'h0, 22'h0, 22'h0, 1'b0);
    while (k < 600) begin
      midCycle();
      if (rspVld) sawR = 1'b1;
      if (reqRdy) break;
      nextCycle();
      k++;
    end
    len = k;
    nextCycle();
  endtask

  initial begin
    rstB = 1'b0;
    applyStimulus(1'b0, 1'b0, 9'h0, 22'h0, 22'h0, 1'b0);
    nextCycle();
    nextCycle();

    // Reset state: {rdy, busy, rsp_vld, cen, gwen, &wen}
    midCycle();
    checkOutput("reset_ctrl", {58'h0, reqRdy, initBusy, rspVld, sramCen, sramGwen, &sramWen},
                {58'h0, 6'b010111});
    checkOutput("reset_rdata", {42'h0, rspRdata}, 64'h0);
    nextCycle();

    // Release reset: the first cycle with reset high writes address 0.
    rstB = 1'b1;
    for (int i = 0; i < 512; i++) begin
      midCycle();
      checkOutput($sformatf("init_sweep_%0d", i),
                  {7'h0, sramCen, sramGwen, sramWen, sramA, sramD, initBusy, reqRdy},
                  {7'h0, 1'b0, 1'b0, 22'h0, 9'(i), 22'h0, 1'b1, 1'b0});
      nextCycle();
    end
    midCycle();
    checkOutput("ready_at_512", {62'h0, reqRdy, initBusy}, {62'h0, 2'b10});
    nextCycle();

    // No access: enables off, address/data follow the request fields.
    applyStimulus(1'b0, 1'b0, 9'h0F0, 22'h012345, 22'h3FFFFF, 1'b0);
    midCycle();
    checkOutput("idle_pins", {9'h0, sramCen, sramGwen, sramWen, sramA, sramD},
                {9'h0, 1'b1, 1'b1, 22'h3FFFFF, 9'h0F0, 22'h012345});
    nextCycle();

    // Full write then read of 0x1A5.
    applyStimulus(1'b1, 1'b1, 9'h1A5, 22'h3FFFFF, 22'h3FFFFF, 1'b0);
    midCycle();
    checkOutput("wr_full_pins", {9'h0, sramCen, sramGwen, sramWen, sramA, sramD},
                {9'h0, 1'b0, 1'b0, 22'h0, 9'h1A5, 22'h3FFFFF});
    nextCycle();
    applyStimulus(1'b1, 1'b0, 9'h1A5, 22'h0, 22'h0, 1'b0);
    midCycle();
    checkOutput("rd_pins", {31'h0, sramCen, sramGwen, sramWen, sramA},
                {31'h0, 1'b0, 1'b1, 22'h3FFFFF, 9'h1A5});
    checkOutput("wr_no_rsp", {63'h0, rspVld}, 64'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 9'h0, 22'h0, 22'h0, 1'b0);
    midCycle();
    checkOutput("rd_full_rsp", {41'h0, rspVld, rspRdata}, {41'h0, 1'b1, 22'h3FFFFF});
    nextCycle();
    midCycle();
    checkOutput("rdata_hold", {41'h0, rspVld, rspRdata}, {41'h0, 1'b0, 22'h3FFFFF});
    nextCycle();

    // Partial write clears the low 11 bits, read immediately after.
    applyStimulus(1'b1, 1'b1, 9'h1A5, 22'h0, 22'h0007FF, 1'b0);
    midCycle();
    checkOutput("wr_part_wen", {42'h0, sramWen}, {42'h0, 22'h3FF800});
    nextCycle();
    applyStimulus(1'b1, 1'b0, 9'h1A5, 22'h0, 22'h0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 9'h0, 22'h0, 22'h0, 1'b0);
    midCycle();
    checkOutput("rd_part_rsp", {41'h0, rspVld, rspRdata}, {41'h0, 1'b1, 22'h3FF800});
    nextCycle();

    // Invalidate together with a read: read refused, sweep restarts.
    applyStimulus(1'b1, 1'b0, 9'h1A5, 22'h0, 22'h0, 1'b1);
    midCycle();
    checkOutput("inv_blocks_rdy", {62'h0, reqRdy, sramCen}, {62'h0, 2'b01});
    nextCycle();
    applyStimulus(1'b0, 1'b0, 9'h0, 22'h0, 22'h0, 1'b0);
    midCycle();
    checkOutput("inv_restart", {52'h0, initBusy, rspVld, sramCen, sramA},
                {52'h0, 1'b1, 1'b0, 1'b0, 9'h000});
    repeat (100) nextCycle();
    applyStimulus(1'b0, 1'b0, 9'h0, 22'h0, 22'h0, 1'b1);
    midCycle();
    checkOutput("inv_mid_sweep", {54'h0, reqRdy, sramA}, {54'h0, 1'b0, 9'd100});
    nextCycle();
    applyStimulus(1'b0, 1'b0, 9'h0, 22'h0, 22'h0, 1'b0);
    midCycle();
    checkOutput("inv_ignored", {55'h0, sramA}, {55'h0, 9'd101});
    nextCycle();
    waitSweepDone(sweepLen, sawRsp);
    checkOutput("inv_sweep_len", 64'(sweepLen), 64'd410);
    checkOutput("inv_sweep_no_rsp", {63'h0, sawRsp}, 64'h0);
    applyStimulus(1'b1, 1'b0, 9'h1A5, 22'h0, 22'h0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 9'h0, 22'h0, 22'h0, 1'b0);
    midCycle();
    checkOutput("rd_after_inv", {41'h0, rspVld, rspRdata}, {41'h0, 1'b1, 22'h0});
    nextCycle();

    // Reset while a read is in flight drops the response.
    applyStimulus(1'b1, 1'b0, 9'h1A5, 22'h0, 22'h0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 9'h0, 22'h0, 22'h0, 1'b0);
    rstB = 1'b0;
    midCycle();
    checkOutput("rst_drops_rsp", {61'h0, rspVld, sramCen, initBusy}, {61'h0, 3'b011});
    nextCycle();
    rstB = 1'b1;
    midCycle();
    checkOutput("rst_rd_restart", {54'h0, sramCen, sramA}, {54'h0, 1'b0, 9'h0});
    nextCycle();
    waitSweepDone(sweepLen, sawRsp);
    checkOutput("rst_rd_sweep_len", 64'(sweepLen), 64'd511);
    checkOutput("rst_rd_no_rsp", {63'h0, sawRsp}, 64'h0);

    // Reset at sweep cycle 300.
    applyStimulus(1'b0, 1'b0, 9'h0, 22'h0, 22'h0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 9'h0, 22'h0, 22'h0, 1'b0);
    repeat (300) nextCycle();
    midCycle();
    checkOutput("sweep_at_300", {55'h0, sramA}, {55'h0, 9'd300});
    nextCycle();
    rstB = 1'b0;
    midCycle();
    checkOutput("rst_sweep_pins", {60'h0, sramCen, rspVld, reqRdy, initBusy}, {60'h0, 4'b1001});
    nextCycle();
    rstB = 1'b1;
    midCycle();
    checkOutput("rst_sweep_restart", {54'h0, sramCen, sramA}, {54'h0, 1'b0, 9'h0});
    nextCycle();
    waitSweepDone(sweepLen, sawRsp);
    checkOutput("rst_sweep_len", 64'(sweepLen), 64'd511);
    checkOutput("rst_sweep_no_rsp", {63'h0, sawRsp}, 64'h0);

    // Back-to-back writes, a masked-off write, then three consecutive reads.
    applyStimulus(1'b1, 1'b1, 9'h010, 22'h0AAAAA, 22'h3FFFFF, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 9'h011, 22'h155555, 22'h3FFFFF, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 9'h012, 22'h2F0F0F, 22'h3FFFFF, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 9'h011, 22'h000000, 22'h000000, 1'b0);
    midCycle();
    checkOutput("wmask0_cen", {63'h0, sramCen}, 64'h1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 9'h010, 22'h0, 22'h0, 1'b0);
    midCycle();
    checkOutput("wmask0_no_rsp", {63'h0, rspVld}, 64'h0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 9'h011, 22'h0, 22'h0, 1'b0);
    midCycle();
    checkOutput("b2b_rsp0", {41'h0, rspVld, rspRdata}, {41'h0, 1'b1, 22'h0AAAAA});
    nextCycle();
    applyStimulus(1'b1, 1'b0, 9'h012, 22'h0, 22'h0, 1'b0);
    midCycle();
    checkOutput("b2b_rsp1", {41'h0, rspVld, rspRdata}, {41'h0, 1'b1, 22'h155555});
    nextCycle();
    applyStimulus(1'b0, 1'b0, 9'h0, 22'h0, 22'h0, 1'b0);
    midCycle();
    checkOutput("b2b_rsp2", {41'h0, rspVld, rspRdata}, {41'h0, 1'b1, 22'h2F0F0F});
    nextCycle();
    midCycle();
    checkOutput("b2b_rsp_end", {63'h0, rspVld}, 64'h0);
    nextCycle();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
